// File: rtl/noc_merge_pkg.sv
// Shared types and constants for the NoC merge path (arbiter side and output stage).
package noc_merge_pkg;

  localparam int FLIT_W = 11;

  localparam logic [1:0] SEL_D1      = 2'd0;
  localparam logic [1:0] SEL_D2      = 2'd1;
  localparam logic [1:0] SEL_CORE    = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  typedef enum logic {
    WAIT_CTRL = 1'b0,
    WAIT_DATA = 1'b1
  } merge_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Storage is cleared on reset so the head flit reads as zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/merge_output_stage.sv
// Merge stage: one control token selects the source of exactly one flit,
// which is queued toward the router output link.
module merge_output_stage
  import noc_merge_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             ctrl_sel,
  input  logic                   ctrl_valid,
  output logic                   ctrl_ready,
  input  logic [WIDTH-1:0]       d1_data,
  input  logic                   d1_valid,
  output logic                   d1_ready,
  input  logic [WIDTH-1:0]       d2_data,
  input  logic                   d2_valid,
  output logic                   d2_ready,
  input  logic [WIDTH-1:0]       core_data,
  input  logic                   core_valid,
  output logic                   core_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       pkt_count,
  output logic                   err_illegal
);

  merge_state_e     state;
  merge_state_e     state_next;
  logic [1:0]       sel_q;
  logic             ctrl_fire;
  logic             data_fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] src_data;

  assign ctrl_fire = ctrl_valid && ctrl_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_CTRL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_CTRL: if (ctrl_fire && ctrl_sel != SEL_ILLEGAL) state_next = WAIT_DATA;
      WAIT_DATA: if (data_fire) state_next = WAIT_CTRL;
      default:   state_next = WAIT_CTRL;
    endcase
  end

  // Readies are gated by rst_n so nothing looks acceptable while reset is held.
  always_comb begin
    ctrl_ready = 1'b0;
    d1_ready   = 1'b0;
    d2_ready   = 1'b0;
    core_ready = 1'b0;
    if (rst_n) begin
      case (state)
        WAIT_CTRL: ctrl_ready = 1'b1;
        WAIT_DATA: begin
          case (sel_q)
            SEL_D1:   d1_ready   = !fifo_full;
            SEL_D2:   d2_ready   = !fifo_full;
            SEL_CORE: core_ready = !fifo_full;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    src_data  = '0;
    data_fire = 1'b0;
    case (sel_q)
      SEL_D1:   begin src_data = d1_data;   data_fire = d1_valid   && d1_ready;   end
      SEL_D2:   begin src_data = d2_data;   data_fire = d2_valid   && d2_ready;   end
      SEL_CORE: begin src_data = core_data; data_fire = core_valid && core_ready; end
      default:  ;
    endcase
  end

  // An illegal token is dropped without touching the latched selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= SEL_D1;
      err_illegal <= 1'b0;
      pkt_count   <= '0;
    end else begin
      if (ctrl_fire && ctrl_sel != SEL_ILLEGAL) sel_q <= ctrl_sel;
      if (ctrl_fire && ctrl_sel == SEL_ILLEGAL) err_illegal <= 1'b1;
      if (data_fire) pkt_count <= pkt_count + CNT_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_fire),
    .pop   (out_valid && out_ready),
    .wdata (src_data),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: doc/merge_output_stage.md
Name: merge_output_stage

Overview:
- Clocked merge stage directly downstream of the input arbiter block.
- Consumes a 2-bit merge-control token and then exactly one 11-bit flit from the source that token names: data path 1, data path 2, or the local core.
- Each accepted flit is buffered in a small output FIFO toward the router output link.
- Provides ordered, one-flit-per-control-token merging, with occupancy and packet statistics.

Parameters:
- WIDTH, 11, flit width in bits.
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the accepted-packet counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ctrl_sel  in  2  merge control token: 0 selects d1, 1 selects d2, 2 selects core, 3 is illegal.
- ctrl_valid  in  1  control token present.
- ctrl_ready  out  1  control token accepted this cycle when high together with ctrl_valid.
- d1_data  in  WIDTH  flit from data path 1.
- d1_valid  in  1  d1 flit present.
- d1_ready  out  1  d1 flit accepted.
- d2_data  in  WIDTH  flit from data path 2.
- d2_valid  in  1  d2 flit present.
- d2_ready  out  1  d2 flit accepted.
- core_data  in  WIDTH  flit from the local core.
- core_valid  in  1  core flit present.
- core_ready  out  1  core flit accepted.
- out_data  out  WIDTH  FIFO head flit.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts the head flit.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- pkt_count  out  CNT_W  flits written into the FIFO since reset; wraps modulo 2^CNT_W.
- err_illegal  out  1  sticky flag; set when a ctrl_sel of 3 is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state is WAIT_CTRL; sel register is 0.
  - FIFO is empty: read pointer, write pointer and count are 0.
  - out_valid=0, out_data=0, fifo_count=0, pkt_count=0, err_illegal=0.
  - All ready outputs are 0 while rst_n is low.
  - Reset asserted mid-transfer discards any latched selection and all FIFO contents. No partial flit survives.
- Handshake: a transfer occurs on the rising edge when valid and ready are both high. Valid must not depend on ready; ready must not depend combinationally on valid.
- State WAIT_CTRL:
  - ctrl_ready=1; all data ready outputs are 0.
  - On a ctrl handshake with sel 0, 1 or 2: latch sel and go to WAIT_DATA.
  - On a ctrl handshake with sel 3: set err_illegal, drop the token and stay in WAIT_CTRL. No data is consumed.
- State WAIT_DATA:
  - ctrl_ready=0.
  - Only the selected source's ready is driven, as ready = !fifo_full. Unselected ready outputs are 0, even if those sources are valid.
  - On a data handshake: write the flit at the write pointer, increment pkt_count, return to WAIT_CTRL.
  - If the selected source is not valid, wait indefinitely; other sources are never consumed out of order.
- Throughput and latency:
  - Maximum throughput is one flit per 2 cycles.
  - Ctrl accepted at edge N and data accepted at edge N+1 gives out_valid=1 after edge N+1 if the FIFO was empty.
  - Minimum ctrl-to-output latency is 2 edges.
- FIFO:
  - out_data is driven from registered storage at the read pointer; out_valid = (count != 0).
  - A pop occurs when out_valid and out_ready are both high.
  - Pointers wrap modulo DEPTH; count is held in a separate register.
  - Full: count == DEPTH. Write ready uses the registered full only, so with a full FIFO no push occurs even if a pop happens in the same cycle. The push completes one cycle later.
  - Simultaneous push and pop when not full: count is unchanged and both pointers advance.
  - Pop when empty is impossible because out_valid=0.
- pkt_count: increments by 1 per FIFO write and wraps from 2^CNT_W-1 to 0 without a flag.
- err_illegal: cleared only by reset.

Decomposition:
- Shared package noc_merge_pkg holds:
  - typedef for the state enum (WAIT_CTRL, WAIT_DATA);
  - localparams SEL_D1=2'd0, SEL_D2=2'd1, SEL_CORE=2'd2, SEL_ILLEGAL=2'd3;
  - the flit width constant FLIT_W=11, shared with the arbiter side.
- One sub-module: sync_fifo (parameters WIDTH and DEPTH; ports push, pop, wdata, rdata, full, empty, count).
- The FSM, source multiplexer and counters live in merge_output_stage.

Test Plan:
- Reset, then ctrl_sel=0 with d1_data=11'h155, out_ready=1 -> out_data=11'h155 and out_valid high 2 edges after ctrl accept; pkt_count=1; d2_ready and core_ready stay 0 throughout.
- d1_valid, d2_valid and core_valid held with 11'h001, 11'h002 and 11'h003; ctrl sequence 2,1,0 -> output order 003, 002, 001; pkt_count=3.
- out_ready=0, six ctrl/data pairs from d2 with values 1..6 -> FIFO fills at 4 and fifo_count=4; d2_ready=0 while full; release out_ready -> 1..6 emerge in order with no loss or duplication.
- ctrl_sel=3 -> err_illegal=1, no data ready asserted, state stays WAIT_CTRL; next ctrl_sel=1 with 11'h7FF -> 11'h7FF output; err_illegal stays 1.
- Assert rst_n low in WAIT_DATA with 2 flits in the FIFO -> immediately out_valid=0, fifo_count=0, pkt_count=0, all ready outputs 0; after release, ctrl_ready=1.
- Force pkt_count to 16'hFFFF via 65535 transfers with random ctrl values 0..2 and random data against a scoreboard -> the next write gives pkt_count=0 and every output flit matches its ctrl-selected source in order.
